wave_analyzer: RTL

Receive-side companion to the wave generator: consumes the 8-bit sample stream and measures it.
- Detects rising threshold crossings with hysteresis.
- Per full period, reports the period (in accepted samples) and the minimum and maximum sample values.
- Sits on the generator's sample output, for on-chip loopback self-test and for measuring external waveforms fed on ui_in.

---
 rtl/wave_analyzer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/wave_analyzer.sv
// Sample-stream analyzer: hysteretic rising-crossing detection with per-period length, min and max.
// Optional duty-cycle output enabled by defining WAVE_ANALYZER_DUTY_EN.
module wave_analyzer #(
    parameter int DATA_W   = 8,
    parameter int PERIOD_W = 16,
    parameter int HYST     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [DATA_W-1:0]   sample_in,
    input  logic                sample_valid,
    input  logic [DATA_W-1:0]   thr,
    output logic [PERIOD_W-1:0] period,
    output logic [DATA_W-1:0]   vmin,
    output logic [DATA_W-1:0]   vmax,
    output logic                meas_valid,
    output logic                timeout
`ifdef WAVE_ANALYZER_DUTY_EN
    ,
    output logic [PERIOD_W-1:0] duty
`endif
);

    typedef enum logic [1:0] {SEARCH_ARM, SEARCH_RISE, MEAS_ARM, MEAS_RISE} state_t;

    localparam logic [DATA_W-1:0]   HYST_T  = DATA_W'(HYST);
    localparam logic [DATA_W:0]     HYST_X  = {1'b0, HYST_T};
    localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

    state_t              state;
    logic [PERIOD_W-1:0] cnt;
    logic [DATA_W-1:0]   wmin;
    logic [DATA_W-1:0]   wmax;
    logic [DATA_W-1:0]   lo;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W:0]     hi_sum;
    logic                is_low;
    logic                is_high;
`ifdef WAVE_ANALYZER_DUTY_EN
    logic [PERIOD_W-1:0] wduty;
    logic                ge_thr;
`endif

    // Saturating hysteresis band around the threshold
    always_comb begin
        hi_sum  = {1'b0, thr} + HYST_X;
        hi      = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];
        lo      = (thr >= HYST_T) ? (thr - HYST_T) : '0;
        is_low  = (sample_in <= lo);
        is_high = (sample_in >= hi);
`ifdef WAVE_ANALYZER_DUTY_EN
        ge_thr  = (sample_in >= thr);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEARCH_ARM;
            cnt        <= '0;
            wmin       <= '0;
            wmax       <= '0;
            period     <= '0;
            vmin       <= '0;
            vmax       <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
`ifdef WAVE_ANALYZER_DUTY_EN
            wduty      <= '0;
            duty       <= '0;
`endif
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            if (!ena) begin
                state <= SEARCH_ARM;
                cnt   <= '0;
                wmin  <= '0;
                wmax  <= '0;
`ifdef WAVE_ANALYZER_DUTY_EN
                wduty <= '0;
`endif
            end else if (sample_valid) begin
                case (state)
                    SEARCH_ARM: begin
                        if (is_low)
                            state <= SEARCH_RISE;
                    end
                    SEARCH_RISE: begin
                        if (is_high) begin
                            state <= MEAS_ARM;
                            cnt   <= CNT_ONE;
                            wmin  <= sample_in;
                            wmax  <= sample_in;
`ifdef WAVE_ANALYZER_DUTY_EN
                            wduty <= {{(PERIOD_W-1){1'b0}}, ge_thr};
`endif
                        end
                    end
                    MEAS_ARM, MEAS_RISE: begin
                        // A rise closes the period; the crossing sample opens the next one
                        if (state == MEAS_RISE && is_high) begin
                            period     <= cnt;
                            vmin       <= wmin;
                            vmax       <= wmax;
                            meas_valid <= 1'b1;
                            state      <= MEAS_ARM;
                            cnt        <= CNT_ONE;
                            wmin       <= sample_in;
                            wmax       <= sample_in;
`ifdef WAVE_ANALYZER_DUTY_EN
                            duty       <= wduty;
                            wduty      <= {{(PERIOD_W-1){1'b0}}, ge_thr};
`endif
                        end else if (cnt == '1) begin
                            timeout <= 1'b1;
                            state   <= SEARCH_ARM;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                            if (sample_in < wmin)
                                wmin <= sample_in;
                            if (sample_in > wmax)
                                wmax <= sample_in;
`ifdef WAVE_ANALYZER_DUTY_EN
                            wduty <= wduty + {{(PERIOD_W-1){1'b0}}, ge_thr};
`endif
                            if (is_low)
                                state <= MEAS_RISE;
                        end
                    end
                    default: state <= SEARCH_ARM;
                endcase
            end
        end
    end

endmodule
